gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and code width in bits (legal range 2..16).
REQ-002 Parameter WRAP, default 1, SHALL select the boundary behaviour: 1 = wrap-around, 0 = saturate.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the count enable; one step per clk edge while high.
REQ-006 up  input  1  SHALL select the direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  SHALL be the synchronous load strobe.
REQ-008 load_gray  input  1  SHALL select the load_val coding: 1 = Gray, 0 = binary.
REQ-009 load_val  input  WIDTH  SHALL be the value to load.
REQ-010 bin  output  WIDTH  SHALL be the registered binary count.
REQ-011 gray  output  WIDTH  SHALL be the registered Gray encoding of bin.
REQ-012 tc  output  1  SHALL be the registered terminal-count flag.

Function
REQ-013 Encoding SHALL be gray = bin XOR (bin >> 1), MSB equal to bin MSB.
REQ-014 Decoding SHALL be bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] XOR g[i], with i descending.
REQ-015 bin and gray SHALL both be flops updated on the same edge, so gray always equals encode(bin) with no combinational path from inputs to outputs.
REQ-016 Latency: load and count effects SHALL appear on the outputs one clk edge after the inputs are sampled.
REQ-017 Priority SHALL be reset > load > en; load=1 ignores en and up.
REQ-018 Load SHALL set bin = load_val when load_gray=0, and bin = decode(load_val) when load_gray=1.
REQ-019 When en=1 and load=0, bin SHALL step by +1 if up=1 and by -1 if up=0, modulo 2^WIDTH.
REQ-020 When en=0 and load=0, bin, gray and the count SHALL hold.
REQ-021 WRAP=1 boundaries: up at all-ones SHALL give 0; down at 0 SHALL give all-ones.
REQ-022 WRAP=0 boundaries: up at all-ones and down at 0 SHALL hold the value.
REQ-023 tc SHALL be set on an edge where en=1, load=0 and bin is at the boundary for the current direction (all-ones for up, 0 for down), and SHALL be cleared on every other edge.
REQ-024 The tc rule SHALL be identical for both WRAP values.
REQ-025 A direction change SHALL take effect on the same edge it is sampled, with no dead cycle.
REQ-026 Every enabled step, including wrap, SHALL change exactly one gray bit.
REQ-027 A saturated hold SHALL change zero gray bits.
REQ-028 A load SHALL be exempt from the single-bit-change rule.

Reset
REQ-029 While rst_n=0, bin, gray and tc SHALL be 0 immediately, without waiting for clk.
REQ-030 Reset asserted mid-count or mid-load SHALL abort the operation with no residual state.
REQ-031 The first edge after rst_n deasserts SHALL be processed normally.

Verification (WIDTH=4 unless stated)
REQ-032 Reset: assert rst_n=0 between edges -> bin=0000, gray=0000, tc=0 with no clk edge.
REQ-033 Binary load: load=1, load_gray=0, load_val=1010 -> next edge gives bin=1010, gray=1111.
REQ-034 Gray load: load=1, load_gray=1, load_val=1111 -> next edge gives bin=1010, gray=1111.
REQ-035 Up wrap: load 1110, then en=1, up=1 for 3 edges -> bin 1111, 0000, 0001; tc=1 only after the 1111->0000 edge.
REQ-036 Saturate: WRAP=0, bin=0000, en=1, up=0 for 2 edges -> bin stays 0000, tc=1 on both edges; then up=1 -> bin=0001, tc=0.
REQ-037 Precedence and sweep:
  - load=1 with en=1, up=1, load_val=0101 -> bin=0101 (load wins).
  - 16 enabled up steps from 0000 -> every gray transition has Hamming distance 1.
  - rst_n pulsed low at step 7 -> all outputs 0.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror, binary or Gray
// parallel load, selectable wrap/saturate boundary and a terminal-count flag.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] gray_encode(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = ALL_ZERO;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             tc_r;
    logic [WIDTH-1:0] bin_next_s;
    logic             tc_next_s;
    logic             at_bound_s;

    // Next-state selection: load beats count; boundary step either wraps or holds.
    always_comb begin
        bin_next_s = bin_r;
        tc_next_s  = 1'b0;
        at_bound_s = up ? (bin_r == ALL_ONES) : (bin_r == ALL_ZERO);
        if (load) begin
            if (load_gray) begin
                bin_next_s = gray_decode(load_val);
            end else begin
                bin_next_s = load_val;
            end
        end else if (en) begin
            tc_next_s = at_bound_s;
            if (at_bound_s && !WRAP) begin
                bin_next_s = bin_r;
            end else if (up) begin
                bin_next_s = bin_r + ONE;
            end else begin
                bin_next_s = bin_r - ONE;
            end
        end else begin
            bin_next_s = bin_r;
        end
    end

    // Binary and Gray copies share one edge so gray always tracks encode(bin).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= ALL_ZERO;
            gray_r <= ALL_ZERO;
            tc_r   <= 1'b0;
        end else begin
            bin_r  <= bin_next_s;
            gray_r <= gray_encode(bin_next_s);
            tc_r   <= tc_next_s;
        end
    end

    assign bin  = bin_r;
    assign gray = gray_r;
    assign tc   = tc_r;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: one wrapping and one saturating instance driven in
// lock-step and compared against an integer reference model.
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic       load_gray;
    logic [3:0] load_val;
    logic [3:0] bin_w, gray_w, bin_s, gray_s;
    logic       tc_w, tc_s;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = wrapping instance, index 1 = saturating instance.
    int unsigned mb[2];
    logic        mt[2];

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin(bin_w), .gray(gray_w), .tc(tc_w)
    );

    gray_counter #(.WIDTH(4), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin(bin_s), .gray(gray_s), .tc(tc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray decode by search: the value whose Gray code matches.
    function automatic int unsigned model_decode(input int unsigned g);
        for (int v = 0; v < 16; v++) begin
            if (((v ^ (v >> 1)) & 15) == g) return v;
        end
        return 0;
    endfunction

    task automatic model_clock();
        int unsigned nb;
        logic bound;
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                mb[k] = load_gray ? model_decode(int'(load_val)) : int'(load_val);
                mt[k] = 1'b0;
            end else if (en) begin
                bound = up ? (mb[k] == 15) : (mb[k] == 0);
                mt[k] = bound;
                nb = up ? (mb[k] + 1) % 16 : (mb[k] + 15) % 16;
                if (k == 1 && bound) nb = mb[k];
                mb[k] = nb;
            end else begin
                mt[k] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mb[k] = 0;
            mt[k] = 1'b0;
        end
    endtask

    task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cmp1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eb0, eb1;
        eb0 = 4'(mb[0]);
        eb1 = 4'(mb[1]);
        cmp4({tag, ".wrap.bin"},  bin_w,  eb0);
        cmp4({tag, ".wrap.gray"}, gray_w, 4'((mb[0] ^ (mb[0] >> 1)) & 15));
        cmp1({tag, ".wrap.tc"},   tc_w,   mt[0]);
        cmp4({tag, ".sat.bin"},   bin_s,  eb1);
        cmp4({tag, ".sat.gray"},  gray_s, 4'((mb[1] ^ (mb[1] >> 1)) & 15));
        cmp1({tag, ".sat.tc"},    tc_s,   mt[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    task automatic set_in(input logic l, input logic lg, input logic [3:0] lv,
                          input logic e, input logic u);
        load = l; load_gray = lg; load_val = lv; en = e; up = u;
    endtask

    // Asynchronous reset pulse placed between edges, checked before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] prev_g;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Binary load 1010 -> bin 1010, gray 1111
        set_in(1'b1, 1'b0, 4'b1010, 1'b0, 1'b0);
        tick();
        check_all("load_bin");
        cmp4("load_bin.const", gray_w, 4'b1111);

        // Gray load 1111 -> bin 1010
        set_in(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        tick();
        check_all("load_gray");
        cmp4("load_gray.const", bin_w, 4'b1010);

        // Up wrap from 1110
        set_in(1'b1, 1'b0, 4'b1110, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("up_wrap");
        end
        cmp4("up_wrap.const", bin_w, 4'b0001);

        // Down at 0: wrapping goes to 1111, saturating holds with tc
        set_in(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            prev_g = gray_s;
            tick();
            check_all("sat_down");
            cmp1("sat_down.tc_const", tc_s, 1'b1);
            cmp4("sat_hold.gray_delta", 4'($countones(prev_g ^ gray_s)), 4'd0);
        end
        up = 1'b1;
        tick();
        check_all("sat_turn_up");
        cmp4("sat_turn_up.const", bin_s, 4'b0001);

        // Hold with en=0
        set_in(1'b0, 1'b0, 4'b1100, 1'b0, 1'b1);
        tick();
        check_all("hold");

        // Load beats enable
        set_in(1'b1, 1'b0, 4'b0101, 1'b1, 1'b1);
        tick();
        check_all("load_prio");
        cmp4("load_prio.const", bin_w, 4'b0101);

        // 16 up steps from 0, single-bit gray change, reset pulse at step 7
        set_in(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            prev_g = gray_w;
            tick();
            check_all("sweep");
            cmp4("sweep.gray_hamming", 4'($countones(prev_g ^ gray_w)), 4'd1);
            if (i == 7) async_reset("sweep_reset");
        end

        // Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom),
                   ($urandom_range(0, 3) != 0), 1'($urandom));
            tick();
            check_all("random");
            if ($urandom_range(0, 49) == 0) async_reset("random_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
